// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath: shared memory port, reused ALU, ready-handshake memory.
// Optional retired-instruction counter enabled by `define MULTICYCLE_PERF_CNT_EN.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           opcode_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 ir_write_o,
  output logic                 iord_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [1:0]           mem_to_reg_o,
  output logic [1:0]           reg_dst_o,
  output logic                 reg_write_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic [1:0]           pc_src_o,
  output logic [3:0]           state_o,
  output logic                 illegal_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] instr_count_o
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_I_EXEC = 4'd7,
    S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_JAL = 4'd11, S_TRAP = 4'd15
  } state_e;

  localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] reg_dst_q, reg_dst_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       wait_hit;
  logic       mem_state;

  // The access that would make the wait count reach the limit traps, unless ready arrives with it.
  assign wait_hit = !mem_ready_i && (({1'b0, wait_q} + 9'd1) >= TO_LIM);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    reg_dst_d    = reg_dst_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 2'b00;
    reg_dst_o    = 2'b00;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_src_o     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = 3'b100;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
        else if (wait_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = 3'b100;
        op_d        = opcode_i;
        case (opcode_i)
          6'h00:                      state_d = S_R_EXEC;
          6'h08, 6'h0F, 6'h0D, 6'h0C: state_d = S_I_EXEC;
          6'h23, 6'h2B:               state_d = S_MEM_ADDR;
          6'h04, 6'h05:               state_d = S_BRANCH;
          6'h02:                      state_d = S_JUMP;
          6'h03:                      state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 3'b101;
        state_d     = (op_q == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ, S_MEM_WRITE: begin
        iord_o      = 1'b1;
        mem_read_o  = (state_q == S_MEM_READ);
        mem_write_o = (state_q == S_MEM_WRITE);
        if (mem_ready_i) state_d = (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        else if (wait_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b01;
        state_d      = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b111;
        reg_dst_d   = 2'b01;
        state_d     = S_ALU_WB;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (op_q)
          6'h08:   alu_op_o = 3'b100;
          6'h0F:   alu_op_o = 3'b001;
          6'h0D:   alu_op_o = 3'b010;
          6'h0C:   alu_op_o = 3'b011;
          default: alu_op_o = 3'b000;
        endcase
        reg_dst_d = 2'b00;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = reg_dst_q;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b110;
        pc_src_o    = 2'b01;
        pc_write_o  = ((op_q == 6'h04) && zero_i) || ((op_q == 6'h05) && !zero_i);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        pc_src_o     = 2'b10;
        pc_write_o   = 1'b1;
        reg_write_o  = 1'b1;
        reg_dst_o    = 2'b10;
        mem_to_reg_o = 2'b10;
        state_d      = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign wait_d    = (mem_state && !mem_ready_i && (state_d == state_q)) ? wait_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      wait_q    <= 8'd0;
      reg_dst_q <= 2'b00;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      reg_dst_q <= reg_dst_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  // TRAP never returns to FETCH, so the count freezes there without extra gating.
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire;
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);
  assign cnt_d  = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign instr_count_o = cnt_q;
`else
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus trap/timeout/reset sequences.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
  logic [1:0]  mem_to_reg_o, reg_dst_o;
  logic        reg_write_o, alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [2:0]  alu_op_o;
  logic [1:0]  pc_src_o;
  logic [3:0]  state_o;
  logic        illegal_o, timeout_o;
  logic [31:0] instr_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .state_o(state_o), .illegal_o(illegal_o),
    .timeout_o(timeout_o), .instr_count_o(instr_count_o)
  );

  always #5 clk = ~clk;

  logic [17:0] ctrl;
  assign ctrl = {pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o,
                 reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o};

  function automatic logic [17:0] c(input logic pcw, irw, iord, mr, mw, input logic [1:0] m2r, rd,
                                    input logic rw, asa, input logic [1:0] asb, input logic [2:0] aop,
                                    input logic [1:0] ps);
    return {pcw, irw, iord, mr, mw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction

  function automatic int ec(input int n);
`ifdef MULTICYCLE_PERF_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  opc;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    int          cnt;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [5:0] opc, input logic z, rdy, input logic [3:0] st,
                     input logic [17:0] ctl, input int cnt);
    vec_t v;
    v.opc = opc; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [17:0] F1, F0, DEC, MA, MR, MW, MWB, REX, WBR, WBI, BR1, BR0, JL, JMP;

  initial begin
    F1  = c(1, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd1, 3'b100, 2'd0);
    F0  = c(0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd1, 3'b100, 2'd0);
    DEC = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd3, 3'b100, 2'd0);
    MA  = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b101, 2'd0);
    MR  = c(0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'b000, 2'd0);
    MW  = c(0, 0, 1, 0, 1, 2'd0, 2'd0, 0, 0, 2'd0, 3'b000, 2'd0);
    MWB = c(0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0, 2'd0, 3'b000, 2'd0);
    REX = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'b111, 2'd0);
    WBR = c(0, 0, 0, 0, 0, 2'd0, 2'd1, 1, 0, 2'd0, 3'b000, 2'd0);
    WBI = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0, 3'b000, 2'd0);
    BR1 = c(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'b110, 2'd1);
    BR0 = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'b110, 2'd1);
    JL  = c(1, 0, 0, 0, 0, 2'd2, 2'd2, 1, 0, 2'd0, 3'b000, 2'd2);
    JMP = c(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'b000, 2'd2);

    // LW with ready every cycle
    add(6'h23, 0, 1, 4'd0, F1, 0);  add(6'h23, 0, 1, 4'd1, DEC, 0);
    add(6'h23, 0, 1, 4'd2, MA, 0);  add(6'h23, 0, 1, 4'd3, MR, 0);
    add(6'h23, 0, 1, 4'd4, MWB, 0);
    // SW with one wait in fetch and one in the write
    add(6'h2B, 0, 0, 4'd0, F0, 1);  add(6'h2B, 0, 1, 4'd0, F1, 1);
    add(6'h2B, 0, 1, 4'd1, DEC, 1); add(6'h2B, 0, 1, 4'd2, MA, 1);
    add(6'h2B, 0, 0, 4'd5, MW, 1);  add(6'h2B, 0, 1, 4'd5, MW, 1);
    // R-type, ORI
    add(6'h00, 0, 1, 4'd0, F1, 2);  add(6'h00, 0, 1, 4'd1, DEC, 2);
    add(6'h00, 0, 1, 4'd6, REX, 2); add(6'h00, 0, 1, 4'd8, WBR, 2);
    add(6'h0D, 0, 1, 4'd0, F1, 3);  add(6'h0D, 0, 1, 4'd1, DEC, 3);
    add(6'h0D, 0, 1, 4'd7, c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b010, 2'd0), 3);
    add(6'h0D, 0, 1, 4'd8, WBI, 3);
    // BEQ taken, BNE not taken (ready ignored in BRANCH)
    add(6'h04, 1, 1, 4'd0, F1, 4);  add(6'h04, 1, 1, 4'd1, DEC, 4);
    add(6'h04, 1, 0, 4'd9, BR1, 4);
    add(6'h05, 1, 1, 4'd0, F1, 5);  add(6'h05, 1, 1, 4'd1, DEC, 5);
    add(6'h05, 1, 1, 4'd9, BR0, 5);
    // JAL, J
    add(6'h03, 0, 1, 4'd0, F1, 6);  add(6'h03, 0, 1, 4'd1, DEC, 6);
    add(6'h03, 0, 1, 4'd11, JL, 6);
    add(6'h02, 0, 1, 4'd0, F1, 7);  add(6'h02, 0, 1, 4'd1, DEC, 7);
    add(6'h02, 0, 0, 4'd10, JMP, 7);
    // LUI, ANDI, ADDI
    add(6'h0F, 0, 1, 4'd0, F1, 8);  add(6'h0F, 0, 1, 4'd1, DEC, 8);
    add(6'h0F, 0, 1, 4'd7, c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b001, 2'd0), 8);
    add(6'h0F, 0, 1, 4'd8, WBI, 8);
    add(6'h0C, 0, 1, 4'd0, F1, 9);  add(6'h0C, 0, 1, 4'd1, DEC, 9);
    add(6'h0C, 0, 1, 4'd7, c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b011, 2'd0), 9);
    add(6'h0C, 0, 1, 4'd8, WBI, 9);
    add(6'h08, 0, 1, 4'd0, F1, 10); add(6'h08, 0, 1, 4'd1, DEC, 10);
    add(6'h08, 0, 1, 4'd7, c(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'b100, 2'd0), 10);
    add(6'h08, 0, 1, 4'd8, WBI, 10);

    opcode_i = 6'h00; zero_i = 1'b0; mem_ready_i = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_ctrl", 32'(ctrl), 32'(F0));
    chk("reset_flags", {30'd0, illegal_o, timeout_o}, 32'd0);
    chk("reset_cnt", instr_count_o, 32'(ec(0)));
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      opcode_i = vq[i].opc; zero_i = vq[i].z; mem_ready_i = vq[i].rdy;
      #1;
      chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vq[i].st));
      chk($sformatf("v%0d_ctrl", i), 32'(ctrl), 32'(vq[i].ctl));
      chk($sformatf("v%0d_cnt", i), instr_count_o, 32'(ec(vq[i].cnt)));
      chk($sformatf("v%0d_flags", i), {30'd0, illegal_o, timeout_o}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("table_end_state", 32'(state_o), 32'd0);
    chk("table_end_cnt", instr_count_o, 32'(ec(11)));
    @(negedge clk);

    // Illegal opcode traps and stays inert
    do_reset();
    opcode_i = 6'h3F; mem_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ill_state", 32'(state_o), 32'd15);
    chk("ill_flag", {30'd0, illegal_o, timeout_o}, 32'd2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      opcode_i = 6'($urandom_range(0, 63)); zero_i = 1'($urandom_range(0, 1));
      mem_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("trap%0d_ctrl", k), 32'(ctrl), 32'd0);
      chk($sformatf("trap%0d_state", k), 32'(state_o), 32'd15);
      chk($sformatf("trap%0d_ill", k), 32'(illegal_o), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("ill_async_rst_state", 32'(state_o), 32'd0);
    chk("ill_async_rst_flag", 32'(illegal_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Timeout: 15 waiting cycles in FETCH trap
    mem_ready_i = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("to14_state", 32'(state_o), 32'd0);
    chk("to14_flag", 32'(timeout_o), 32'd0);
    @(negedge clk);
    #1;
    chk("to15_state", 32'(state_o), 32'd15);
    chk("to15_flags", {30'd0, illegal_o, timeout_o}, 32'd1);
    chk("to15_ctrl", 32'(ctrl), 32'd0);

    // Ready on the 15th cycle wins over the timeout
    do_reset();
    mem_ready_i = 1'b0;
    repeat (14) @(negedge clk);
    mem_ready_i = 1'b1;
    #1;
    chk("rdy15_ctrl", 32'(ctrl), 32'(F1));
    @(negedge clk);
    #1;
    chk("rdy15_state", 32'(state_o), 32'd1);
    chk("rdy15_flag", 32'(timeout_o), 32'd0);
    @(negedge clk);

    // Async reset in the middle of a store after one retired jump
    do_reset();
    opcode_i = 6'h02; mem_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    opcode_i = 6'h2B;
    repeat (3) @(negedge clk);
    mem_ready_i = 1'b0;
    #1;
    chk("sw_pre_state", 32'(state_o), 32'd5);
    chk("sw_pre_cnt", instr_count_o, 32'(ec(1)));
    reset_n = 1'b0;
    #1;
    chk("sw_rst_state", 32'(state_o), 32'd0);
    chk("sw_rst_cnt", instr_count_o, 32'd0);
    chk("sw_rst_memwr", 32'(mem_write_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    chk("sw_rel_ctrl", 32'(ctrl), 32'(F1));
    @(negedge clk);
    #1;
    chk("sw_rel_state", 32'(state_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencer for the multi-cycle MIPS datapath variant. One shared memory port serves both instruction and data accesses, and the ALU is reused for PC increment and branch target.
- Decodes the same opcode set as the single-cycle control unit and steps the datapath through fetch/decode/execute/memory/writeback, one state per cycle.
- Handles variable memory latency via a ready handshake, and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 15: max consecutive cycles waiting on mem_ready_i before trapping (1..255).
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode_i  input  6  instruction[31:26] from the instruction register.
- zero_i  input  1  ALU zero flag.
- mem_ready_i  input  1  memory completes the current access this cycle.
- pc_write_o  output  1  PC load enable.
- ir_write_o  output  1  instruction register load enable.
- iord_o  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read_o  output  1  memory read request.
- mem_write_o  output  1  memory write request.
- mem_to_reg_o  output  2  write-data select: 00=ALUOut, 01=MDR, 10=PC.
- reg_dst_o  output  2  destination select: 00=rt, 01=rd, 10=$31.
- reg_write_o  output  1  register file write enable.
- alu_src_a_o  output  1  ALU A select: 0=PC, 1=rs.
- alu_src_b_o  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op_o  output  3  ALU op: 111=R(funct), 100=add, 001=lui, 010=or, 011=and, 101=mem add, 110=sub, 000=none.
- pc_src_o  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- state_o  output  4  current state encoding, for debug.
- illegal_o  output  1  sticky flag: illegal-opcode trap.
- timeout_o  output  1  sticky flag: memory-timeout trap.
- instr_count_o  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (async, reset_n=0):
  - state=FETCH(0); op_q=0; wait_cnt=0; illegal_o=0, timeout_o=0, instr_count_o=0.
  - All outputs take their FETCH-state decode.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, I_EXEC 7, ALU_WB 8, BRANCH 9, JUMP 10, JAL 11, TRAP 15.
- Output defaults: every unlisted output is 0 in each state.
- FETCH:
  - Outputs: mem_read_o=1, iord_o=0, alu_src_b_o=01, alu_op_o=100, pc_src_o=00.
  - ir_write_o and pc_write_o equal mem_ready_i.
  - On mem_ready_i go to DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_b_o=11, alu_op_o=100 (branch target into ALUOut). op_q<=opcode_i.
  - Dispatch:
    - 0x00 -> R_EXEC.
    - 0x08/0x0F/0x0D/0x0C -> I_EXEC.
    - 0x23/0x2B -> MEM_ADDR.
    - 0x04/0x05 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x03 -> JAL.
    - any other opcode -> TRAP, setting illegal_o.
- MEM_ADDR:
  - Outputs: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=101.
  - Next state: MEM_READ if op_q=0x23, else MEM_WRITE.
- MEM_READ:
  - Outputs: mem_read_o=1, iord_o=1.
  - On mem_ready_i go to MEM_WB.
- MEM_WRITE:
  - Outputs: mem_write_o=1, iord_o=1.
  - On mem_ready_i go to FETCH.
- MEM_WB: reg_write_o=1, mem_to_reg_o=01, reg_dst_o=00; then FETCH.
- R_EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=111; then ALU_WB with reg_dst_o=01.
- I_EXEC:
  - Outputs: alu_src_a_o=1, alu_src_b_o=10.
  - alu_op_o by op_q: 0x08->100, 0x0F->001, 0x0D->010, 0x0C->011.
  - Then ALU_WB with reg_dst_o=00.
- ALU_WB:
  - Outputs: reg_write_o=1, mem_to_reg_o=00.
  - reg_dst_o is held from the originating state by reg_dst_q; then FETCH.
- BRANCH:
  - Outputs: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=110, pc_src_o=01.
  - pc_write_o = (op_q==0x04 & zero_i) | (op_q==0x05 & ~zero_i).
  - Then FETCH.
- JUMP: pc_src_o=10, pc_write_o=1; then FETCH.
- JAL: pc_src_o=10, pc_write_o=1, reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10, all in the same cycle; then FETCH.
- Memory wait counter:
  - wait_cnt increments each cycle in FETCH/MEM_READ/MEM_WRITE while mem_ready_i=0.
  - Clears on mem_ready_i and on any state change.
  - When wait_cnt reaches MEM_TIMEOUT with mem_ready_i still 0, go to TRAP and set timeout_o.
  - mem_ready_i=1 in the same cycle as the timeout wins: the access completes and no trap occurs.
- mem_ready_i in any non-memory state is ignored.
- TRAP:
  - All enables are 0. Stays in TRAP until reset; flags stay sticky.
- Retirement: an instruction retires on any transition into FETCH from a state other than FETCH.
- Reset mid-access aborts immediately; the next cycle after release is FETCH.

Optional Feature:
- MULTICYCLE_PERF_CNT_EN defined:
  - instr_count_o increments by 1 on each retirement.
  - Wraps modulo 2^CNT_WIDTH and freezes in TRAP.
- Not defined: instr_count_o is tied to 0 and no counter flops are synthesized.

Test Plan:
- LW, 0x23, mem_ready_i=1 every cycle:
  - Visits FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH (5 cycles).
  - MEM_WB shows reg_write_o=1, mem_to_reg_o=01; instr_count_o=1 with PERF enabled.
- BEQ 0x04 with zero_i=1: pc_write_o=1 and pc_src_o=01 in BRANCH. BNE 0x05 with zero_i=1: pc_write_o=0 in BRANCH.
- JAL 0x03: a single JAL cycle asserts pc_write_o=1, reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10.
- Opcode 0x3F in DECODE: state_o=15, illegal_o=1, and all enables stay 0 for 20 further cycles.
- mem_ready_i held 0 in FETCH with MEM_TIMEOUT=15: TRAP after 15 wait cycles with timeout_o=1. Repeating with mem_ready_i=1 on the 15th cycle gives no trap and goes to DECODE.
- reset_n low mid-MEM_WRITE: state_o=0 and all flags/counters 0 asynchronously; the fetch restarts correctly after release.
